// File: rtl/wb_cmd_master.sv
// Command-driven Wishbone pipelined initiator with one outstanding access at a time.
// Re-issues an access when the slave answers RTY, and bounds every access with a timeout.
module wb_cmd_master #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,

    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic                  cmd_we_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [3:0]            cmd_sel_i,
    input  logic [31:0]           cmd_dat_i,

    output logic                  rsp_valid_o,
    input  logic                  rsp_ready_i,
    output logic [31:0]           rsp_dat_o,
    output logic [1:0]            rsp_sts_o,

    output logic                  wb_cyc_o,
    output logic                  wb_stb_o,
    output logic [ADDR_WIDTH-1:0] wb_adr_o,
    output logic [3:0]            wb_sel_o,
    output logic                  wb_we_o,
    output logic [31:0]           wb_dat_o,
    input  logic                  wb_ack_i,
    input  logic                  wb_err_i,
    input  logic                  wb_rty_i,
    input  logic                  wb_stall_i,
    input  logic [31:0]           wb_dat_i
);

    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
    localparam int unsigned RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    localparam logic [1:0] STS_OK  = 2'b00;
    localparam logic [1:0] STS_ERR = 2'b01;
    localparam logic [1:0] STS_RTY = 2'b10;
    localparam logic [1:0] STS_TMO = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_GAP,
        S_RSP
    } state_t;

    state_t                  state_q,     state_d;
    logic                    cyc_q,       cyc_d;
    logic                    stb_q,       stb_d;
    logic [ADDR_WIDTH-1:0]   adr_q,       adr_d;
    logic [3:0]              sel_q,       sel_d;
    logic                    we_q,        we_d;
    logic [31:0]             dat_q,       dat_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [31:0]             rsp_dat_q,   rsp_dat_d;
    logic [1:0]              rsp_sts_q,   rsp_sts_d;
    logic [RTY_W-1:0]        retry_cnt_q, retry_cnt_d;
    logic [TMO_W-1:0]        tmo_cnt_q,   tmo_cnt_d;

    logic                    term;
    logic                    tmo_hit;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= S_IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            dat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_dat_q   <= '0;
            rsp_sts_q   <= STS_OK;
            retry_cnt_q <= '0;
            tmo_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_dat_q   <= rsp_dat_d;
            rsp_sts_q   <= rsp_sts_d;
            retry_cnt_q <= retry_cnt_d;
            tmo_cnt_q   <= tmo_cnt_d;
        end
    end

    assign term = wb_ack_i | wb_err_i | wb_rty_i;
    // >= rather than == so a retry taken on the last counted cycle still times out in the gap
    assign tmo_hit = (tmo_cnt_q >= TMO_LAST);

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        sel_d       = sel_q;
        we_d        = we_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_dat_d   = rsp_dat_q;
        rsp_sts_d   = rsp_sts_q;
        retry_cnt_d = retry_cnt_q;
        tmo_cnt_d   = tmo_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i) begin
                    adr_d       = cmd_adr_i;
                    sel_d       = cmd_sel_i;
                    we_d        = cmd_we_i;
                    dat_d       = cmd_dat_i;
                    cyc_d       = 1'b1;
                    stb_d       = 1'b1;
                    retry_cnt_d = '0;
                    tmo_cnt_d   = '0;
                    state_d     = S_REQ;
                end
            end

            S_REQ, S_WAIT: begin
                if (term) begin
                    if (wb_err_i) begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = '0;
                        rsp_sts_d   = STS_ERR;
                        state_d     = S_RSP;
                    end else if (wb_rty_i) begin
                        if (retry_cnt_q < RTY_MAX) begin
                            retry_cnt_d = retry_cnt_q + 1'b1;
                            tmo_cnt_d   = tmo_cnt_q + 1'b1;
                            cyc_d       = 1'b0;
                            stb_d       = 1'b0;
                            state_d     = S_GAP;
                        end else begin
                            cyc_d       = 1'b0;
                            stb_d       = 1'b0;
                            rsp_valid_d = 1'b1;
                            rsp_dat_d   = '0;
                            rsp_sts_d   = STS_RTY;
                            state_d     = S_RSP;
                        end
                    end else begin
                        cyc_d       = 1'b0;
                        stb_d       = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_dat_d   = we_q ? 32'h0 : wb_dat_i;
                        rsp_sts_d   = STS_OK;
                        state_d     = S_RSP;
                    end
                end else if (tmo_hit) begin
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_sts_d   = STS_TMO;
                    state_d     = S_RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    if ((state_q == S_REQ) && !wb_stall_i) begin
                        stb_d   = 1'b0;
                        state_d = S_WAIT;
                    end
                end
            end

            // One idle cycle with cyc low before the access is re-issued
            S_GAP: begin
                if (tmo_hit) begin
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = '0;
                    rsp_sts_d   = STS_TMO;
                    state_d     = S_RSP;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    state_d   = S_REQ;
                end
            end

            S_RSP: begin
                if (rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end

            default: begin
                cyc_d       = 1'b0;
                stb_d       = 1'b0;
                rsp_valid_d = 1'b0;
                state_d     = S_IDLE;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == S_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_dat_o   = rsp_dat_q;
    assign rsp_sts_o   = rsp_sts_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign wb_adr_o    = adr_q;
    assign wb_sel_o    = sel_q;
    assign wb_we_o     = we_q;
    assign wb_dat_o    = dat_q;

    // Bus-protocol invariants; ignored by synthesis
    a_stb_in_cyc : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        wb_stb_o |-> wb_cyc_o);

    a_rsp_hold : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_dat_o) && $stable(rsp_sts_o)));

endmodule
